// File: rtl/mac_mem_responder.sv
// Avalon-MM-style read responder standing in for the MAC-FIFO matrix/vector ROM.
// Fixed-latency in-order responses, bounded outstanding reads, optional periodic waitrequest stalls.
module mac_mem_responder #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 9,
  parameter int ADDR_W      = 4,
  parameter int LATENCY     = 2,
  parameter int MAX_OUT     = 2,
  parameter int STALL_EVERY = 0,
  parameter int STALL_LEN   = 3
) (
  input  logic              CLOCK_50,
  input  logic              KEY0,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  output logic              waitrequest,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              err
);

  typedef enum logic {RUN, STALL} stall_state_t;

  stall_state_t       state, state_nxt;
  logic [15:0]        acc_cnt, acc_cnt_nxt;
  logic [3:0]         stall_cnt, stall_cnt_nxt;
  logic               stall_wr;
  logic [3:0]         outstanding;
  logic               full;
  logic               accept;
  logic               in_range;
  logic [DATA_W-1:0]  rd_word;
  logic [LATENCY-1:0] vld_p;
  logic [DATA_W-1:0]  data_p [LATENCY];

  // Byte b of word i holds 8*i+b+1, so every byte in the image is distinct.
  function automatic logic [DATA_W-1:0] rom_word(input int idx);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      w[8*b +: 8] = 8'(8 * idx + b + 1);
    end
    return w;
  endfunction

  assign accept   = read && !waitrequest;
  assign in_range = int'(address) < DEPTH;
  assign rd_word  = in_range ? rom_word(int'(address)) : '0;

  // Stage p0 captures the looked-up word at the accepting edge; the last stage is the output.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      vld_p <= '0;
      for (int i = 0; i < LATENCY; i++) data_p[i] <= '0;
    end else begin
      vld_p[0]  <= accept;
      data_p[0] <= accept ? rd_word : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        data_p[i] <= data_p[i-1];
      end
    end
  end

  assign readdatavalid = vld_p[LATENCY-1];
  assign readdata      = data_p[LATENCY-1];

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      case ({accept, readdatavalid})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
      if (accept && !in_range) err <= 1'b1;
    end
  end

  assign full = (outstanding == 4'(MAX_OUT));

  // A response retiring this cycle frees a slot, so a full responder can still accept.
  assign waitrequest = stall_wr || (full && !readdatavalid);

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state     <= RUN;
      acc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      acc_cnt   <= acc_cnt_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_cnt_nxt   = acc_cnt;
    stall_cnt_nxt = stall_cnt;
    case (state)
      RUN: begin
        if (STALL_EVERY != 0 && accept) begin
          if (acc_cnt == 16'(STALL_EVERY - 1)) begin
            state_nxt     = STALL;
            stall_cnt_nxt = 4'(STALL_LEN);
            acc_cnt_nxt   = '0;
          end else begin
            acc_cnt_nxt = acc_cnt + 16'd1;
          end
        end
      end
      STALL: begin
        stall_cnt_nxt = stall_cnt - 4'd1;
        if (stall_cnt == 4'd1) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall_wr = (state == STALL);
  end

endmodule
